dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10000000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access; legal range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  CPU memory stage presents a request.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  CPU consumes the response.
REQ-014 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  access was misaligned or out of range.

Function
REQ-016 SHALL be a three-state FSM: IDLE, WAIT, RESP; at most one request outstanding.
REQ-017 SHALL drive req_ready from a register: 1 only in IDLE; 0 in WAIT and RESP.
REQ-018 SHALL accept a request on an edge where req_valid and req_ready are both 1; the request fields are sampled on that edge.
REQ-019 SHALL flag an error when req_addr[1:0] != 0, req_addr < BASE_ADDR, or req_addr >= BASE_ADDR + 4*DEPTH_WORDS.
REQ-020 SHALL compute the word index as (req_addr - BASE_ADDR) >> 2.
REQ-021 SHALL commit a non-error store to the array on the acceptance edge, updating only the enabled bytes; req_be = 4'b0000 updates nothing and is acknowledged normally.
REQ-022 SHALL capture non-error load data on the acceptance edge and return the full word regardless of req_be.
REQ-023 SHALL never modify the array for an error access.
REQ-024 SHALL go from IDLE on acceptance to WAIT when WAIT_CYCLES > 0, otherwise directly to RESP.
REQ-025 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP.
REQ-026 SHALL assert resp_valid exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-027 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until the edge where resp_ready = 1.
REQ-028 SHALL, on that edge, return to IDLE, clear resp_valid, resp_rdata and resp_err to 0, and raise req_ready for the next cycle.
REQ-029 SHALL give minimum back-to-back request spacing of WAIT_CYCLES+2 cycles.
REQ-030 SHALL ignore resp_ready outside RESP.
REQ-031 SHALL ignore req_valid outside IDLE; the requester holds its request until req_ready is seen.
REQ-032 SHALL make a load issued after a completed store to the same word return the new data.

Reset
REQ-033 SHALL, while rst_n = 0, force FSM = IDLE, wait counter = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-034 SHALL raise req_ready on the first rising clk edge after rst_n deasserts.
REQ-035 SHALL abort an in-flight access when reset asserts mid-operation, with no response issued; a store already committed on its acceptance edge remains.
REQ-036 SHALL NOT reset or clear array contents.

Structure
REQ-037 SHALL take from shared package dmem_pkg: the FSM state typedef (IDLE/WAIT/RESP), the default BASE_ADDR constant, and the word/byte-enable width constants.
REQ-038 SHALL use one sub-module, dmem_array: a synchronous single-port word RAM with 4-bit byte-write enable.
REQ-039 SHALL keep FSM, wait counter, range/alignment checking and response registers in dmem_responder.

Verification (defaults unless stated)
REQ-040 SHALL be verified by: store 32'hDEADBEEF to 32'h10000004 with be 4'hF, then load 32'h10000004 -> store response err=0, rdata=0; load rdata=32'hDEADBEEF, resp_valid rising 3 cycles after acceptance.
REQ-041 SHALL be verified by: store 32'h000000AA to 32'h10000004 with be 4'b0001 over 32'hDEADBEEF -> later load returns 32'hDEADBEAA.
REQ-042 SHALL be verified by: load 32'h10000002 and load 32'h10001000 -> both give resp_err=1, rdata=0, and the array is unchanged.
REQ-043 SHALL be verified by: resp_ready held 0 for 5 cycles in RESP -> outputs stable throughout, req_ready=0, req_valid ignored; the pending request is accepted the cycle after resp_ready=1.
REQ-044 SHALL be verified by: rst_n pulsed low during WAIT of a load -> no resp_valid, outputs 0, req_ready=1 one edge after release, and previously stored data intact.
REQ-045 SHALL be verified by: WAIT_CYCLES=0 with back-to-back loads and resp_ready tied 1 -> resp_valid one cycle after each acceptance, accepts every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word RAM.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset so it maps onto RAM macros and keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding request, IDLE -> WAIT -> RESP handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              err_q, load_q;
    logic              accept, addr_err, ram_en;
    logic [31:0]       offset;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] ram_rdata;

    assign accept   = req_valid & req_ready;
    // The upper bound is compared in 33 bits so a region ending at 4 GiB cannot wrap.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT);
    assign ram_en   = accept & ~addr_err;
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = AW'(offset >> 2);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (req_we),
        .be    (req_be),
        .addr  (word_idx),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = 4'd0;
                    state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            req_ready  <= (state_nx == IDLE);
            resp_valid <= (state_nx == RESP);
            if (accept) begin
                err_q  <= addr_err;
                load_q <= ~req_we & ~addr_err;
            end
        end
    end

    // The RAM read register holds the captured word; outside RESP both outputs read as zero.
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = {WORD_W{resp_valid & load_q}} & ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a 2-wait-state instance for the main scenarios and a 0-wait instance for throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        req_valid_z, req_ready_z, req_we_z, resp_valid_z, resp_ready_z, resp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, resp_rdata_z;
    logic [3:0]  req_be_z;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
        .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one access on the 2-wait instance starting at a negedge; lat = negedges from acceptance
    // until resp_valid is seen, -1 if any handshake times out.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (!resp_valid) return;
        lat   = n;
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h expected all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", req_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({req_ready, req_ready_z} !== 2'b11)
            $display("FAIL ready_after_release: got %b expected 11", {req_ready, req_ready_z});
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        total_cnt++;
        if ({er, rd} !== 33'd0 || lat !== 3)
            $display("FAIL store_resp: got err=%b rdata=%h lat=%0d expected 0 00000000 3", er, rd, lat);
        else pass_cnt++;
        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0)
            $display("FAIL load_data: got %h err=%b expected deadbeef err=0", rd, er);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 3) $display("FAIL load_latency: got %0d expected 3", lat);
        else pass_cnt++;
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h1000_0004, 32'h0000_00AA, 4'b0001, rd, er, lat);
        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'hDEAD_BEAA) $display("FAIL byte_lane0: got %h expected deadbeaa", rd);
        else pass_cnt++;
        access(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0000, rd, er, lat);
        total_cnt++;
        if (er !== 1'b0 || lat !== 3) $display("FAIL be_zero_ack: got err=%b lat=%0d expected 0 3", er, lat);
        else pass_cnt++;
        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'hDEAD_BEAA) $display("FAIL be_zero_data: got %h expected deadbeaa", rd);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        access(1'b0, 32'h1000_0002, 32'h0, 4'hF, rd, er, lat);
        total_cnt++;
        if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL misaligned_load: got err=%b rdata=%h expected 1 00000000", er, rd);
        else pass_cnt++;
        access(1'b0, 32'h1000_1000, 32'h0, 4'hF, rd, er, lat);
        total_cnt++;
        if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL range_load: got err=%b rdata=%h expected 1 00000000", er, rd);
        else pass_cnt++;
        access(1'b1, 32'h1000_0006, 32'h5555_5555, 4'hF, rd, er, lat);
        total_cnt++;
        if (er !== 1'b1) $display("FAIL misaligned_store: got err=%b expected 1", er);
        else pass_cnt++;
        access(1'b1, 32'h0FFF_FFFC, 32'h6666_6666, 4'hF, rd, er, lat);
        total_cnt++;
        if (er !== 1'b1) $display("FAIL below_base_store: got err=%b expected 1", er);
        else pass_cnt++;
        access(1'b1, 32'h1000_1000, 32'h7777_7777, 4'hF, rd, er, lat);
        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'hDEAD_BEAA) $display("FAIL array_unchanged: got %h expected deadbeaa", rd);
        else pass_cnt++;
        access(1'b1, 32'h1000_0FFC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        access(1'b0, 32'h1000_0FFC, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if ({er, rd} !== {1'b0, 32'hCAFE_F00D}) $display("FAIL last_word: got err=%b rdata=%h expected 0 cafef00d", er, rd);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        req_we = 1'b0; req_addr = 32'h1000_0004; req_be = 4'hF; req_wdata = '0;
        req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h1000_0FFC;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        total_cnt++;
        if (resp_valid !== 1'b1) $display("FAIL bp_resp_timeout: got vld=%b expected 1", resp_valid);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({resp_valid, resp_err, req_ready, resp_rdata} !== {3'b100, 32'hDEAD_BEAA})
                $display("FAIL bp_hold_%0d: got vld=%b err=%b rdy=%b rdata=%h expected 1 0 0 deadbeaa",
                         i, resp_valid, resp_err, req_ready, resp_rdata);
            else pass_cnt++;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total_cnt++;
        if ({resp_valid, resp_err, req_ready, resp_rdata} !== {3'b001, 32'h0})
            $display("FAIL bp_release: got vld=%b err=%b rdy=%b rdata=%h expected 0 0 1 00000000",
                     resp_valid, resp_err, req_ready, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL bp_pending_accept: got rdy=%b expected 0", req_ready);
        else pass_cnt++;
        n = 1;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        total_cnt++;
        if (resp_rdata !== 32'hCAFE_F00D || n !== 3)
            $display("FAIL bp_pending_data: got rdata=%h lat=%0d expected cafef00d 3", resp_rdata, n);
        else pass_cnt++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic abort_in_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic saw_valid;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = 4'hF; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0)
            $display("FAIL abort_outputs: got rdy=%b vld=%b err=%b rdata=%h expected all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        saw_valid = resp_valid;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | resp_valid;
        end
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL abort_no_resp: got vld=%b expected 0", saw_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        abort_in_wait(1'b1, 32'h1000_0008, 32'h1111_1111);
        abort_in_wait(1'b0, 32'h1000_0004, 32'h0);
        access(1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'h1111_1111) $display("FAIL abort_store_kept: got %h expected 11111111", rd);
        else pass_cnt++;
        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        total_cnt++;
        if (rd !== 32'hDEAD_BEAA) $display("FAIL abort_data_intact: got %h expected deadbeaa", rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic        we_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad_v [4] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0000, 32'h1000_0004};
        logic [31:0] wd_v [4] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0};
        logic [31:0] ex_v [4] = '{32'h0, 32'h0, 32'hA5A5_0001, 32'h5A5A_0002};
        time prev_t, acc_t;
        int  n;
        prev_t = 0;
        resp_ready_z = 1'b1;
        req_valid_z  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_we_z = we_v[k]; req_addr_z = ad_v[k]; req_wdata_z = wd_v[k]; req_be_z = 4'hF;
            n = 0;
            while (!req_ready_z && n < 10) begin @(negedge clk); n++; end
            @(posedge clk);
            acc_t = $time;
            @(negedge clk);
            total_cnt++;
            if ({resp_valid_z, resp_err_z, resp_rdata_z} !== {2'b10, ex_v[k]})
                $display("FAIL zw_resp_%0d: got vld=%b err=%b rdata=%h expected 1 0 %h",
                         k, resp_valid_z, resp_err_z, resp_rdata_z, ex_v[k]);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if ((acc_t - prev_t) !== 64'd20)
                    $display("FAIL zw_spacing_%0d: got %0t expected 20", k, acc_t - prev_t);
                else pass_cnt++;
            end
            prev_t = acc_t;
        end
        req_valid_z = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
        resp_ready_z = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
